// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared constants for the 8-bit timer count register.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

  // Default counter width of the timer
  localparam int TCNT_WIDTH = 8;

  // Terminal values of the default-width counter
  localparam logic [TCNT_WIDTH-1:0] CNT_MAX = {TCNT_WIDTH{1'b1}};
  localparam logic [TCNT_WIDTH-1:0] CNT_MIN = '0;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter
//  Description : Loadable up/down count register (reg_TCNT) stepping once per
//                prescaler tick, with sticky overflow/underflow wrap flags.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = TCNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,          // active-high synchronous reset
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] start_counter,
  input  logic             up_down,
  input  logic             load,
  input  logic             enable,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  output logic             overflow,
  output logic             underflow
);

  // Terminal values derived from the instance width so a non-default WIDTH
  // still wraps at its own boundaries.
  localparam logic [WIDTH-1:0] c_cnt_max = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_cnt_min = '0;

  logic [WIDTH-1:0] reg_TCNT;
  logic [WIDTH-1:0] w_next_cnt;
  logic             w_step;
  logic             w_ovf_wrap;
  logic             w_und_wrap;

  // A step happens only on a gated tick that is not overridden by a load.
  assign w_step     = enable & clk_ena & ~load;
  assign w_ovf_wrap = w_step &  up_down & (reg_TCNT == c_cnt_max);
  assign w_und_wrap = w_step & ~up_down & (reg_TCNT == c_cnt_min);

  // Next-count selection: load beats counting, counting wraps modulo 2^WIDTH.
  always_comb begin
    w_next_cnt = reg_TCNT;
    if (load) begin
      w_next_cnt = start_counter;
    end else if (w_step) begin
      if (up_down) begin
        w_next_cnt = reg_TCNT + 1'b1;
      end else begin
        w_next_cnt = reg_TCNT - 1'b1;
      end
    end
  end

  // Count register update; reset has priority over every other input.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      reg_TCNT <= '0;
    end else begin
      reg_TCNT <= w_next_cnt;
    end
  end

  // Sticky overflow flag: a wrap on the same edge as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow <= 1'b0;
    end else if (w_ovf_wrap) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Sticky underflow flag: a wrap on the same edge as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      underflow <= 1'b0;
    end else if (w_und_wrap) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule : timer_counter
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_counter
//  Description : Self-checking bench for timer_counter: a table of single-edge
//                vectors followed by hand-written multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_counter;

  logic       clk;
  logic       rst_n;
  logic       clk_ena;
  logic [7:0] start_counter;
  logic       up_down;
  logic       load;
  logic       enable;
  logic       clr_overflow;
  logic       clr_underflow;
  logic       overflow;
  logic       underflow;

  int checks;
  int errors;

  typedef struct {
    logic       ld;
    logic [7:0] st;
    logic       ud;
    logic       en;
    logic       ce;
    logic       co;
    logic       cu;
    logic [7:0] exp_cnt;
    logic       exp_ovf;
    logic       exp_und;
  } vec_t;

  vec_t vecs [14];

  timer_counter #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_ena       (clk_ena),
    .start_counter (start_counter),
    .up_down       (up_down),
    .load          (load),
    .enable        (enable),
    .clr_overflow  (clr_overflow),
    .clr_underflow (clr_underflow),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] st, input logic ud,
                       input logic en, input logic ce, input logic co, input logic cu);
    load          = ld;
    start_counter = st;
    up_down       = ud;
    enable        = en;
    clk_ena       = ce;
    clr_overflow  = co;
    clr_underflow = cu;
  endtask

  // One active edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [7:0] cnt, input logic ovf, input logic und);
    check({name, ".cnt"}, dut.reg_TCNT, cnt);
    check({name, ".ovf"}, {7'd0, overflow}, {7'd0, ovf});
    check({name, ".und"}, {7'd0, underflow}, {7'd0, und});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //               ld  st     ud  en  ce  co  cu  cnt    ovf  und
    vecs[0]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

    // Reset held 5 clocks while the other inputs try to load and count.
    rst_n = 1'b1;
    drive(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step();
    check_all("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("post_reset_idle", 8'h00, 1'b0, 1'b0);

    // Table: one edge per vector, state checked after the edge.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ld, vecs[i].st, vecs[i].ud, vecs[i].en, vecs[i].ce, vecs[i].co, vecs[i].cu);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_ovf, vecs[i].exp_und);
    end

    // Clear both flags, then load 10 and count down with a tick every 2nd clk.
    drive(1'b1, 8'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check_all("down_load", 8'd10, 1'b0, 1'b0);
    for (int t = 1; t <= 11; t++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      if (t <= 10) begin
        check_all($sformatf("down_tick%0d", t), 8'(10 - t), 1'b0, 1'b0);
      end else begin
        check_all("down_wrap", 8'hFF, 1'b0, 1'b1);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end

    // Underflow stays set while counting continues.
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check_all("sticky_und", 8'hFC, 1'b0, 1'b1);

    // Single-clock clear pulse, counter untouched.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check_all("clr_und", 8'hFC, 1'b0, 1'b0);

    // Up wrap from 0xFD: two ticks reach 0xFF, third wraps and sets overflow.
    drive(1'b1, 8'hFD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int t = 1; t <= 2; t++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check_all("up_ff", 8'hFF, 1'b0, 1'b0);
    step();
    check_all("up_wrap", 8'h00, 1'b1, 1'b0);

    // Clear pulse alone drops the overflow flag.
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_all("clr_ovf", 8'h00, 1'b0, 1'b0);

    // Count a little, then reset mid-count with a tick and load pending.
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    step();
    check_all("pre_midreset", 8'h02, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_all("mid_reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_timer_counter
`default_nettype wire
